bcd_serial_add_ctrl: RTL and testbench
======================================

// Module: bcd_serial_add_ctrl
// PURPOSE
// - Digit-serial BCD addition controller for the switch/HEX adder design.
// - Captures two NDIGITS-digit BCD operands on a start/done handshake.
// - Feeds one digit pair per clock through a single shared 1-digit BCD adder,
//   LSD first, and returns an (NDIGITS+1)-digit BCD sum to the display decoders.
// - Replaces per-digit parallel adders with one time-shared adder.
// PARAMETERS
// - NDIGITS  2  BCD digits per operand (>=1); sum is NDIGITS+1 digits
// PORTS
// - CLOCK_50  in   1             sole clock, rising edge
// - Resetn    in   1             asynchronous, active-low reset
// - start     in   1             request; sampled only in IDLE
// - a_bcd     in   4*NDIGITS     operand A, digit i = a_bcd[4i+3:4i]
// - b_bcd     in   4*NDIGITS     operand B, same packing
// - cin       in   1             carry-in to digit 0, captured with operands
// - busy      out  1             high while in ADD
// - done      out  1             one-cycle pulse; sum_bcd valid from this cycle
// - sum_bcd   out  4*(NDIGITS+1) result; top digit is final carry (0/1)
// - err       out  1             present only with BCD_CHECK_EN
// BEHAVIOUR
// - Reset (async, Resetn=0): state=IDLE, busy=0, done=0, sum_bcd=0, err=0,
//   internal digit index, carry and operand registers cleared.
// - FSM: IDLE -> ADD on start=1 (edge 0: a_bcd, b_bcd, cin captured, idx=0).
//   ADD: one digit per cycle, idx 0..NDIGITS-1; after idx=NDIGITS-1 -> DONE.
//   DONE: one cycle, done=1, then -> IDLE unconditionally.
// - Latency: done high in the cycle NDIGITS+1 clocks after the accept edge.
// - Per-digit rule: s = a_i + b_i + c (5-bit unsigned); if s > 9 then
//   digit = (s + 6)[3:0], c' = 1; else digit = s[3:0], c' = 0.
// - Partial digits go to a shadow register; sum_bcd updates only on entry
//   to DONE (shadow digits plus final carry as top digit) and holds until
//   the next DONE. Never shows partial results.
// - start while busy or in DONE: ignored, no queueing; operands sampled
//   only at the accept edge, later operand changes have no effect.
// - Reset mid-operation: immediate abort to reset values; no done pulse.
// - Invalid digits (>9), without BCD_CHECK_EN: processed by the rule above,
//   no flag. Example: 15+15+1 = 31 gives digit 5, carry 1.
// CONFIGURATION
// - `BCD_CHECK_EN defined: err port exists. If any captured a/b digit >9 at
//   its ADD cycle, go to DONE the next edge (early), sum_bcd=0, err=1 with
//   done. err holds until the next accepted start, which clears it.
// - Not defined: no err port and no check; fixed NDIGITS+1 latency always.
// STRUCTURE
// - Package bcd_pkg: typedef bcd_digit_t (logic [3:0]), BCD_MAX=4'd9,
//   BCD_ADJ=4'd6, FSM enum ctrl_state_t {IDLE, ADD, DONE}.
// - Sub-module bcd_digit_add: combinational a,b,cin -> digit,cout using the
//   per-digit rule. Instantiated once and time-shared by the controller FSM.
// TESTING (NDIGITS=2)
// - A=47, B=85, cin=0, start -> done 3 clks after accept; sum_bcd=0x132,
//   busy high exactly 2 cycles.
// - A=99, B=99, cin=1 -> sum_bcd=0x199; A=00, B=00, cin=0 -> 0x000.
// - start held high through ADD and DONE -> exactly one done per
//   accept; second op starts in the IDLE cycle after DONE.
// - Change a_bcd mid-ADD -> result uses captured value; sum_bcd keeps
//   previous result until done.
// - Resetn low during ADD -> all outputs 0 at once; no done; next start
//   gives correct result.
// - Invalid digit A=0x3F, B=0x01: with BCD_CHECK_EN, done 2 clks after
//   accept, err=1, sum_bcd=0. Without it, done at 3 clks, sum_bcd=0x046.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD adder slice.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_ADJ = 4'd6;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } ctrl_state_t;

  function automatic logic digit_valid(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder: digit = a + b + cin with decimal adjust.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  output bcd_digit_t digit,
  output logic       cout
);

  logic [4:0] s;
  logic [4:0] s_adj;

  always_comb begin
    s     = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    s_adj = s + {1'b0, BCD_ADJ};
    // Invalid digits wrap through the same rule; bit 4 of s_adj is discarded.
    if (s > {1'b0, BCD_MAX}) begin
      digit = s_adj[3:0];
      cout  = 1'b1;
    end else begin
      digit = s[3:0];
      cout  = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD add controller; one shared digit adder, LSD first.
// Optional BCD_CHECK_EN adds the err port and early abort on digits > 9.
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned NDIGITS = 2
) (
  input  logic                       CLOCK_50,
  input  logic                       Resetn,
  input  logic                       start,
  input  logic [4*NDIGITS-1:0]       a_bcd,
  input  logic [4*NDIGITS-1:0]       b_bcd,
  input  logic                       cin,
  output logic                       busy,
  output logic                       done,
  output logic [4*(NDIGITS+1)-1:0]   sum_bcd
`ifdef BCD_CHECK_EN
  ,
  output logic                       err
`endif
);

  localparam int unsigned IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  ctrl_state_t          state, state_nxt;
  logic [IW-1:0]        idx;
  logic                 carry;
  logic [4*NDIGITS-1:0] a_reg, b_reg;
  logic [4*NDIGITS-1:0] shadow, shadow_nxt;

  bcd_digit_t cur_a, cur_b, cur_sum;
  logic       cur_cout;
  logic       last;
  logic       bad;

  always_comb begin
    cur_a = '0;
    cur_b = '0;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_a = a_reg[4*i +: 4];
        cur_b = b_reg[4*i +: 4];
      end
    end
  end

  bcd_digit_add u_digit_add (
    .a     (cur_a),
    .b     (cur_b),
    .cin   (carry),
    .digit (cur_sum),
    .cout  (cur_cout)
  );

  always_comb begin
    shadow_nxt = shadow;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (idx == IW'(i)) shadow_nxt[4*i +: 4] = cur_sum;
    end
  end

  assign last = (idx == IW'(NDIGITS - 1));

`ifdef BCD_CHECK_EN
  assign bad = !digit_valid(cur_a) || !digit_valid(cur_b);
`else
  assign bad = 1'b0;
`endif

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ADD;
      end
      ADD: begin
        busy = 1'b1;
        if (bad || last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operands frozen at accept; sum_bcd only written on entry to DONE.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      a_reg   <= '0;
      b_reg   <= '0;
      carry   <= 1'b0;
      idx     <= '0;
      shadow  <= '0;
      sum_bcd <= '0;
`ifdef BCD_CHECK_EN
      err     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg  <= a_bcd;
            b_reg  <= b_bcd;
            carry  <= cin;
            idx    <= '0;
            shadow <= '0;
`ifdef BCD_CHECK_EN
            err    <= 1'b0;
`endif
          end
        end
        ADD: begin
          shadow <= shadow_nxt;
          carry  <= cur_cout;
          idx    <= idx + IW'(1);
          if (bad) begin
            sum_bcd <= '0;
`ifdef BCD_CHECK_EN
            err     <= 1'b1;
`endif
          end else if (last) begin
            sum_bcd <= {3'b000, cur_cout, shadow_nxt};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl (NDIGITS=2), transaction-level model.
module tb_bcd_serial_add_ctrl;

  localparam int unsigned ND = 2;
  localparam int unsigned W  = 4 * ND;
  localparam int unsigned SW = 4 * (ND + 1);
`ifdef BCD_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          CLOCK_50 = 1'b0;
  logic          Resetn   = 1'b0;
  logic          start    = 1'b0;
  logic          cin      = 1'b0;
  logic [W-1:0]  a_bcd    = '0;
  logic [W-1:0]  b_bcd    = '0;
  logic          busy, done;
  logic [SW-1:0] sum_bcd;
`ifdef BCD_CHECK_EN
  logic          err;
`endif

  bcd_serial_add_ctrl #(.NDIGITS(ND)) dut (
    .CLOCK_50 (CLOCK_50),
    .Resetn   (Resetn),
    .start    (start),
    .a_bcd    (a_bcd),
    .b_bcd    (b_bcd),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum_bcd  (sum_bcd)
`ifdef BCD_CHECK_EN
    ,
    .err      (err)
`endif
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;
  logic [SW-1:0] last_exp = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal arithmetic when all digits are valid; otherwise the digit rule applies.
  function automatic logic [SW-1:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic c);
    logic [SW-1:0] r;
    logic [3:0] da, db;
    bit valid;
    int va, vb, p, total, s, cy;
    r = '0; valid = 1'b1; va = 0; vb = 0; p = 1;
    for (int i = 0; i < ND; i++) begin
      da = a[4*i +: 4];
      db = b[4*i +: 4];
      if (da > 9 || db > 9) valid = 1'b0;
      va += int'(da) * p;
      vb += int'(db) * p;
      p *= 10;
    end
    if (valid) begin
      total = va + vb + int'(c);
      for (int i = 0; i < ND + 1; i++) begin
        r[4*i +: 4] = 4'(total % 10);
        total = total / 10;
      end
    end else begin
      cy = int'(c);
      for (int i = 0; i < ND; i++) begin
        s = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + cy;
        if (s > 9) begin r[4*i +: 4] = 4'(s + 6); cy = 1; end
        else       begin r[4*i +: 4] = 4'(s);     cy = 0; end
      end
      r[4*ND +: 4] = 4'(cy);
    end
    return r;
  endfunction

  function automatic int first_bad(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [3:0] da, db;
    for (int i = 0; i < ND; i++) begin
      da = a[4*i +: 4];
      db = b[4*i +: 4];
      if (da > 9 || db > 9) return i;
    end
    return -1;
  endfunction

  // Transaction model: remaining busy cycles, then a one-cycle done.
  int            m_left = 0;
  bit            m_done = 1'b0;
  bit            m_err  = 1'b0;
  bit            m_perr = 1'b0;
  logic [SW-1:0] m_sum  = '0;
  logic [SW-1:0] m_pend = '0;

  always @(posedge CLOCK_50 or negedge Resetn) begin
    int fb;
    if (!Resetn) begin
      m_left = 0; m_done = 1'b0; m_err = 1'b0; m_perr = 1'b0; m_sum = '0; m_pend = '0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_sum  = m_pend;
        m_err  = m_perr;
      end
    end else if (start) begin
      fb = first_bad(a_bcd, b_bcd);
      m_err = 1'b0;
      if (CHK && fb >= 0) begin
        m_left = fb + 1; m_pend = '0; m_perr = 1'b1;
      end else begin
        m_left = ND; m_pend = model_sum(a_bcd, b_bcd, cin); m_perr = 1'b0;
      end
    end
  end

  always @(negedge CLOCK_50) begin
    if (Resetn && chk_on) begin
      chk("cyc_busy", 32'(busy), 32'(m_left > 0));
      chk("cyc_done", 32'(done), 32'(m_done));
      chk("cyc_sum", 32'(sum_bcd), 32'(m_sum));
`ifdef BCD_CHECK_EN
      chk("cyc_err", 32'(err), 32'(m_err));
`endif
    end
  end

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic [SW-1:0] exp, input int lat,
                        input bit exp_err, input bit mutate);
    int n, nb;
    @(negedge CLOCK_50);
    a_bcd = a; b_bcd = b; cin = c; start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    if (mutate) begin a_bcd = 8'h99; b_bcd = 8'h99; cin = 1'b1; end
    n = 1; nb = 0;
    while (!done && n < 12) begin
      if (busy) nb++;
      if (mutate) chk({name, "_hold"}, 32'(sum_bcd), 32'(last_exp));
      @(negedge CLOCK_50);
      n++;
    end
    chk({name, "_lat"}, 32'(n), 32'(lat));
    chk({name, "_sum"}, 32'(sum_bcd), 32'(exp));
    chk({name, "_busycyc"}, 32'(nb), 32'(lat - 1));
`ifdef BCD_CHECK_EN
    chk({name, "_err"}, 32'(err), 32'(exp_err));
`else
    if (exp_err) chk({name, "_err_unexpected"}, 32'(exp_err), 32'd0);
`endif
    last_exp = exp;
  endtask

  initial begin
    int ndone;
    chk("model_47_85", 32'(model_sum(8'h47, 8'h85, 1'b0)), 32'h132);
    chk("model_99_99_1", 32'(model_sum(8'h99, 8'h99, 1'b1)), 32'h199);
    chk("model_0f_0f_1", 32'(model_sum(8'h0F, 8'h0F, 1'b1)), 32'h015);
    chk("model_3f_01", 32'(model_sum(8'h3F, 8'h01, 1'b0)), 32'h046);

    repeat (3) @(negedge CLOCK_50);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum_bcd), 32'd0);
    #2 Resetn = 1'b1;
    @(negedge CLOCK_50);
    chk_on = 1'b1;

    run_op("a47_b85", 8'h47, 8'h85, 1'b0, 12'h132, 3, 1'b0, 1'b0);
    run_op("a99_b99_c1", 8'h99, 8'h99, 1'b1, 12'h199, 3, 1'b0, 1'b0);
    run_op("zero", 8'h00, 8'h00, 1'b0, 12'h000, 3, 1'b0, 1'b0);
    run_op("mutate", 8'h12, 8'h34, 1'b0, 12'h046, 3, 1'b0, 1'b1);
    run_op("inv_3f_01", 8'h3F, 8'h01, 1'b0, CHK ? 12'h000 : 12'h046, CHK ? 2 : 3, CHK, 1'b0);
    run_op("inv_0f_0f_1", 8'h0F, 8'h0F, 1'b1, CHK ? 12'h000 : 12'h015, CHK ? 2 : 3, CHK, 1'b0);
    run_op("after_inv", 8'h50, 8'h50, 1'b0, 12'h100, 3, 1'b0, 1'b0);

    // start held high: one done per accept, back-to-back every four cycles
    @(negedge CLOCK_50);
    a_bcd = 8'h21; b_bcd = 8'h13; cin = 1'b0; start = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(negedge CLOCK_50);
      if (done) ndone++;
    end
    start = 1'b0;
    chk("held_start_dones", 32'(ndone), 32'd3);
    repeat (5) @(negedge CLOCK_50);
    chk("held_start_sum", 32'(sum_bcd), 32'h034);

    // reset during ADD aborts at once
    @(negedge CLOCK_50);
    a_bcd = 8'h55; b_bcd = 8'h55; start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    chk("pre_abort_busy", 32'(busy), 32'd1);
    #2 Resetn = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum_bcd), 32'd0);
    ndone = 0;
    repeat (4) begin
      @(negedge CLOCK_50);
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    #2 Resetn = 1'b1;
    last_exp = '0;
    run_op("after_rst", 8'h55, 8'h55, 1'b0, 12'h110, 3, 1'b0, 1'b0);

    // random traffic, including start during busy/done and mid-op operand changes
    repeat (400) begin
      @(negedge CLOCK_50);
      start = ($urandom_range(0, 2) == 0);
      cin   = 1'($urandom_range(0, 1));
      for (int i = 0; i < ND; i++) begin
        a_bcd[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                      : 4'($urandom_range(0, 9));
        b_bcd[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                      : 4'($urandom_range(0, 9));
      end
    end
    start = 1'b0;
    repeat (6) @(negedge CLOCK_50);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
